// File: rtl/pipe_pkg.sv
// Shared register-file geometry and scoreboard types.
package pipe_pkg;

  localparam int unsigned N_REGS = 8;
  localparam int unsigned ADDR_W = 3;
  localparam int unsigned CNT_W  = 2;

  typedef logic [ADDR_W-1:0] reg_addr_t;
  typedef logic [CNT_W-1:0]  cnt_t;

  localparam cnt_t CNT_MAX = cnt_t'((1 << CNT_W) - 1);

endpackage

// File: rtl/sb_entry.sv
// One register's in-flight write counter with increment, retire, clear and underflow detect.
import pipe_pkg::*;

module sb_entry (
  input  logic clk,
  input  logic rst,
  input  logic inc,
  input  logic wb_hit,
  input  logic clear,
  output cnt_t cnt,
  output logic underflow
);

  cnt_t cnt_q, cnt_d;
  logic dec;

  always_comb begin
    dec       = wb_hit & (cnt_q != '0);
    underflow = wb_hit & (cnt_q == '0) & ~clear;
    cnt_d     = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (inc & ~dec) begin
      cnt_d = cnt_q + cnt_t'(1);
    end else if (dec & ~inc) begin
      cnt_d = cnt_q - cnt_t'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/reg_scoreboard.sv
// Pending-write scoreboard gating decode issue on RAW hazards and in-flight saturation.
// Define SB_WB_BYPASS_EN to let a same-cycle writeback release the last pending write.
import pipe_pkg::*;

module reg_scoreboard (
  input  logic      clk,
  input  logic      rst,
  input  logic      issue_valid,
  input  reg_addr_t issue_rs1,
  input  logic      issue_rs1_used,
  input  reg_addr_t issue_rs2,
  input  logic      issue_rs2_used,
  input  reg_addr_t issue_rd,
  input  logic      issue_rd_write,
  input  logic      wb_valid,
  input  reg_addr_t wb_rd,
  input  logic      flush,
  output logic      stall,
  output logic      issue_fire,
  output logic      busy,
  output logic      err
);

  cnt_t [N_REGS-1:0] cnt;
  logic [N_REGS-1:0] underflow;
  logic [N_REGS-1:0] pending;
  logic              hazard, full, inc, err_q;

  for (genvar g = 0; g < N_REGS; g++) begin : gen_entry
    sb_entry u_entry (
      .clk       (clk),
      .rst       (rst),
      .inc       (inc & (issue_rd == reg_addr_t'(g))),
      .wb_hit    (wb_valid & (wb_rd == reg_addr_t'(g))),
      .clear     (flush),
      .cnt       (cnt[g]),
      .underflow (underflow[g])
    );
  end

  always_comb begin
    for (int r = 0; r < N_REGS; r++) begin
`ifdef SB_WB_BYPASS_EN
      // Write-first regfile: the retiring last write is already readable.
      pending[r] = (cnt[r] != '0) &&
                   !((cnt[r] == cnt_t'(1)) && wb_valid && (wb_rd == reg_addr_t'(r)));
`else
      pending[r] = (cnt[r] != '0);
`endif
    end
  end

  always_comb begin
    hazard = (issue_rs1_used & pending[issue_rs1]) | (issue_rs2_used & pending[issue_rs2]);
`ifdef SB_WB_BYPASS_EN
    full   = issue_rd_write & (cnt[issue_rd] == CNT_MAX) & ~(wb_valid & (wb_rd == issue_rd));
`else
    full   = issue_rd_write & (cnt[issue_rd] == CNT_MAX);
`endif
  end

  assign stall      = issue_valid & (hazard | full);
  assign issue_fire = issue_valid & ~stall;
  assign inc        = issue_fire & issue_rd_write;
  assign busy       = |cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_q <= 1'b0;
    end else if (|underflow) begin
      err_q <= 1'b1;
    end
  end

  assign err = err_q;

endmodule
